llc_req_sched: RTL

LLC_REQ_SCHED -- requirements
Module: llc_req_sched

---
 rtl/llc_req_sched_pkg.sv | 24 ++
 rtl/llc_req_sched_pick.sv | 31 +++
 rtl/llc_req_sched.sv | 109 ++++++++++
 3 files changed

// File: rtl/llc_req_sched_pkg.sv
// Source encoding shared by the LLC request scheduler: one-hot grant vector,
// bit indices per source, and the scheduler FSM state constants.
package llc_req_sched_pkg;

  localparam int SRC_N       = 5;
  localparam int SRC_RST_TB  = 0;
  localparam int SRC_MEM_RSP = 1;
  localparam int SRC_RSP     = 2;
  localparam int SRC_REQ     = 3;
  localparam int SRC_DMA     = 4;

  typedef logic [SRC_N-1:0] src_onehot_t;

  localparam src_onehot_t SRC_NONE       = 5'b00000;
  localparam src_onehot_t SRC_OH_RST_TB  = 5'b00001;
  localparam src_onehot_t SRC_OH_MEM_RSP = 5'b00010;
  localparam src_onehot_t SRC_OH_RSP     = 5'b00100;
  localparam src_onehot_t SRC_OH_REQ     = 5'b01000;
  localparam src_onehot_t SRC_OH_DMA     = 5'b10000;

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_BUSY = 1'b1;

endpackage

// File: rtl/llc_req_sched_pick.sv
// Combinational winner selection: fixed priority with starvation promotion of
// req and a round-robin tie-break between req and dma.
module llc_sched_pick
  import llc_req_sched_pkg::*;
(
  input  logic [SRC_N-1:0] elig_i,
  input  logic             rr_dma_first_i,
  input  logic             promote_i,
  output logic [SRC_N-1:0] winner_o
);

  always_comb begin
    winner_o = SRC_NONE;
    if (elig_i[SRC_RST_TB]) begin
      winner_o = SRC_OH_RST_TB;
    end else if (elig_i[SRC_MEM_RSP]) begin
      winner_o = SRC_OH_MEM_RSP;
    end else if (promote_i && elig_i[SRC_REQ]) begin
      winner_o = SRC_OH_REQ;
    end else if (elig_i[SRC_RSP]) begin
      winner_o = SRC_OH_RSP;
    end else if (elig_i[SRC_REQ] && elig_i[SRC_DMA]) begin
      winner_o = rr_dma_first_i ? SRC_OH_DMA : SRC_OH_REQ;
    end else if (elig_i[SRC_REQ]) begin
      winner_o = SRC_OH_REQ;
    end else if (elig_i[SRC_DMA]) begin
      winner_o = SRC_OH_DMA;
    end
  end

endmodule

// File: rtl/llc_req_sched.sv
// LLC request scheduler: arbitrates five sources into the LLC pipeline, one
// transaction in flight at a time, with starvation protection for req_in.
module llc_req_sched
  import llc_req_sched_pkg::*;
#(
  parameter int STARVE_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rst_tb_valid,
  input  logic       llc_mem_rsp_valid,
  input  logic       llc_rsp_in_valid,
  input  logic       llc_req_in_valid,
  input  logic       llc_dma_req_in_valid,
  output logic       rst_tb_ready,
  output logic       llc_mem_rsp_ready,
  output logic       llc_rsp_in_ready,
  output logic       llc_req_in_ready,
  output logic       llc_dma_req_in_ready,
  input  logic       req_blocked,
  input  logic       mshr_avail,
  input  logic       core_idle,
  input  logic       core_done,
  output logic [4:0] grant,
  output logic       grant_valid
);

  logic [0:0]       state_q, state_d;
  logic [SRC_N-1:0] grant_q, grant_d;
  logic             rr_q, rr_d;
  logic [3:0]       starve_q, starve_d;

  logic [SRC_N-1:0] elig;
  logic [SRC_N-1:0] winner;
  logic [SRC_N-1:0] ready_vec;
  logic             is_idle;
  logic             promote;
  logic             transfer;

  assign is_idle = (state_q == STATE_IDLE);
  assign promote = (int'(starve_q) == STARVE_MAX);

  assign elig[SRC_RST_TB]  = rst_tb_valid;
  assign elig[SRC_MEM_RSP] = llc_mem_rsp_valid;
  assign elig[SRC_RSP]     = llc_rsp_in_valid;
  assign elig[SRC_REQ]     = llc_req_in_valid & ~req_blocked & mshr_avail;
  assign elig[SRC_DMA]     = llc_dma_req_in_valid & ~req_blocked;

  llc_sched_pick u_pick (
    .elig_i         (elig),
    .rr_dma_first_i (rr_q),
    .promote_i      (promote),
    .winner_o       (winner)
  );

  // Winner is already gated by eligibility, so a ready always implies a transfer.
  assign ready_vec = winner & {SRC_N{is_idle & core_idle}};
  assign transfer  = |ready_vec;

  assign rst_tb_ready         = ready_vec[SRC_RST_TB];
  assign llc_mem_rsp_ready    = ready_vec[SRC_MEM_RSP];
  assign llc_rsp_in_ready     = ready_vec[SRC_RSP];
  assign llc_req_in_ready     = ready_vec[SRC_REQ];
  assign llc_dma_req_in_ready = ready_vec[SRC_DMA];

  assign grant       = grant_q;
  assign grant_valid = (state_q == STATE_BUSY);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    starve_d = starve_q;

    if (is_idle) begin
      if (transfer) begin
        state_d = STATE_BUSY;
        grant_d = winner;
        if (winner[SRC_REQ]) rr_d = 1'b1;
        if (winner[SRC_DMA]) rr_d = 1'b0;
      end
    end else if (core_done) begin
      state_d = STATE_IDLE;
      grant_d = SRC_NONE;
    end

    // Saturating count of IDLE cycles where req could have gone but did not.
    if (!llc_req_in_valid || ready_vec[SRC_REQ]) begin
      starve_d = 4'd0;
    end else if (is_idle && elig[SRC_REQ] && (starve_q != 4'hF)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= STATE_IDLE;
      grant_q  <= SRC_NONE;
      rr_q     <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      starve_q <= starve_d;
    end
  end

endmodule
